// File: rtl/display_link_pkg.sv
// Shared constants for the display serial link: symbol width codes,
// control-word bit positions and the return-line deframer state type.
package display_link_pkg;

  typedef logic [3:0] width_t;

  // Link-clock high time, in samples, for each symbol kind
  localparam width_t W_PIX0    = 4'd5;
  localparam width_t W_PIXSOF0 = 4'd6;
  localparam width_t W_PIX1    = 4'd8;
  localparam width_t W_PIXSOF1 = 4'd9;
  localparam width_t W_IDLE0   = 4'd10;
  localparam width_t W_IDLE1   = 4'd7;
  localparam width_t W_FRAME   = 4'd12;

  localparam int SAMPLES_PER_SYMBOL = 16;
  localparam int CTRL_BITS          = 16;

  // Control word layout
  localparam int CW_SDA      = 15;
  localparam int CW_SCL      = 14;
  localparam int CW_WE       = 12;
  localparam int CW_ADDR_LSB = 8;
  localparam int CW_DATA_LSB = 0;

  typedef enum logic {
    RX_HUNT = 1'b0,
    RX_CAP  = 1'b1
  } rx_state_e;

  // Width code for a non-FRAME symbol
  function automatic width_t sym_width(input logic has_pix, input logic sof,
                                       input logic cbit);
    width_t w;
    if (!has_pix)  w = cbit ? W_IDLE1 : W_IDLE0;
    else if (sof)  w = cbit ? W_PIXSOF1 : W_PIXSOF0;
    else           w = cbit ? W_PIX1 : W_PIX0;
    return w;
  endfunction

  // Link-clock samples of nibble nib: sample index {nib,b} is high while below w
  function automatic logic [3:0] clk_nibble(input width_t w, input logic [1:0] nib);
    logic [3:0] r;
    for (int b = 0; b < 4; b++) begin
      r[b] = ({nib, 2'(b)} < w);
    end
    return r;
  endfunction

endpackage

// File: rtl/display_host_rx.sv
// Return-line deframer: hunts for a start bit, captures a 6-bit status
// packet, and reassembles 2-bit readback chunks into 16-bit words.
//
// state   | meaning
// --------+-------------------------------------------------------------
// RX_HUNT | idle, waiting for sdo=1 start bit
// RX_CAP  | capturing b0..b5; cnt counts captured bits, b5 taken live
module display_host_rx
  import display_link_pkg::*;
(
  input  logic        c,
  input  logic        reset_n,
  input  logic        sdo,
  output logic        sda_d,
  output logic        scl_d,
  output logic        fifostat,
  output logic        status_valid,
  output logic [15:0] rdata,
  output logic        rdata_valid
);

  rx_state_e   state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [4:0]  sh_q, sh_d;
  logic        pkt_done;

  logic        sda_q, sda_nx;
  logic        scl_q, scl_nx;
  logic        fifo_q, fifo_nx;
  logic        stat_v_q, stat_v_d;

  logic [15:0] asm_q, asm_d;
  logic [2:0]  idx_q, idx_d;
  logic        act_q, act_d;
  logic [15:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic [15:0] merged;
  logic [1:0]  chunk;
  logic        first;

  // Deframer state register
  always_ff @(posedge c or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RX_HUNT;
      cnt_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
    end
  end

  // Deframer next state: b0..b4 shift in from the top, b5 is used directly
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    unique case (state_q)
      RX_HUNT: begin
        if (sdo) begin
          state_d = RX_CAP;
          cnt_d   = 3'd0;
        end
      end
      RX_CAP: begin
        if (cnt_q == 3'd5) begin
          state_d = RX_HUNT;
        end else begin
          sh_d  = {sdo, sh_q[4:1]};
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: state_d = RX_HUNT;
    endcase
  end

  // Deframer outputs: packet completes on the cycle carrying b5
  always_comb begin
    pkt_done = (state_q == RX_CAP) && (cnt_q == 3'd5);
  end

  // Status update and readback-word assembly on each completed packet
  always_comb begin
    chunk    = sh_q[4:3];
    first    = sdo;
    sda_nx   = sda_q;
    scl_nx   = scl_q;
    fifo_nx  = fifo_q;
    stat_v_d = 1'b0;
    asm_d    = asm_q;
    idx_d    = idx_q;
    act_d    = act_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    merged   = asm_q;
    merged[{idx_q, 1'b0} +: 2] = chunk;
    if (pkt_done) begin
      scl_nx   = sh_q[0];
      sda_nx   = sh_q[1];
      fifo_nx  = sh_q[2];
      stat_v_d = 1'b1;
      if (first) begin
        // a new first chunk silently abandons any partial word
        asm_d = {14'd0, chunk};
        idx_d = 3'd1;
        act_d = 1'b1;
      end else if (act_q) begin
        if (idx_q == 3'd7) begin
          rdata_d  = merged;
          rvalid_d = 1'b1;
          act_d    = 1'b0;
          idx_d    = 3'd0;
        end else begin
          asm_d = merged;
          idx_d = idx_q + 3'd1;
        end
      end
    end
  end

  // Status and readback registers
  always_ff @(posedge c or negedge reset_n) begin
    if (!reset_n) begin
      sda_q    <= 1'b0;
      scl_q    <= 1'b0;
      fifo_q   <= 1'b0;
      stat_v_q <= 1'b0;
      asm_q    <= '0;
      idx_q    <= '0;
      act_q    <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      sda_q    <= sda_nx;
      scl_q    <= scl_nx;
      fifo_q   <= fifo_nx;
      stat_v_q <= stat_v_d;
      asm_q    <= asm_d;
      idx_q    <= idx_d;
      act_q    <= act_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign sda_d        = sda_q;
  assign scl_d        = scl_q;
  assign fifostat     = fifo_q;
  assign status_valid = stat_v_q;
  assign rdata        = rdata_q;
  assign rdata_valid  = rvalid_q;

endmodule

// File: rtl/display_host.sv
// Host end of the display link. Each 4-cycle symbol is decided in the last
// cycle of the previous symbol, then emitted as four registered nibbles of
// link-clock and data samples. The return line is handled by display_host_rx.
module display_host
  import display_link_pkg::*;
#(
  parameter int CTRL_INTERVAL = 64  // symbols per frame interval, 20..1023
) (
  input  logic        c,
  input  logic        reset_n,
  output logic [3:0]  clock_q,
  output logic [3:0]  sdi_q,
  input  logic        sdo,
  input  logic        pix_valid,
  input  logic        pix_sof,
  input  logic [15:0] pix_data,
  output logic        pix_ready,
  input  logic        sda_t,
  input  logic        scl_t,
  input  logic        wr_valid,
  input  logic [3:0]  wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_ready,
  output logic        sda_d,
  output logic        scl_d,
  output logic        fifostat,
  output logic        status_valid,
  output logic [15:0] rdata,
  output logic        rdata_valid
);

  localparam logic [9:0] LAST_SYM = 10'(CTRL_INTERVAL - 1);

  logic        run_q;
  logic [1:0]  phase_q, phase_d;
  logic [9:0]  nxt_q, nxt_d;
  width_t      w_q, w_d;
  logic [15:0] pix_q, pix_d;
  logic [15:0] ctrl_q, ctrl_d;
  logic [3:0]  clk_nib_d, sdi_nib_d;
  logic        boundary;
  logic        wr_take;
  logic        cbit;
  logic [3:0]  cidx;

  // Symbol sequencer: picks the next symbol on the last cycle of the current one.
  // run_q is low only in the first cycle after reset release, so the very first
  // FRAME never accepts a write (there is no preceding symbol to carry it).
  always_comb begin
    boundary  = (phase_q == 2'd3);
    wr_take   = run_q && wr_valid;
    phase_d   = phase_q + 2'd1;
    nxt_d     = nxt_q;
    w_d       = w_q;
    pix_d     = pix_q;
    ctrl_d    = ctrl_q;
    pix_ready = 1'b0;
    wr_ready  = 1'b0;
    cidx      = nxt_q[3:0] - 4'd1;
    cbit      = 1'b0;
    if (boundary) begin
      nxt_d = (nxt_q == LAST_SYM) ? 10'd0 : nxt_q + 10'd1;
      if (nxt_q == 10'd0) begin
        w_d            = W_FRAME;
        pix_d          = '0;
        ctrl_d         = '0;
        ctrl_d[CW_SDA] = sda_t;
        ctrl_d[CW_SCL] = scl_t;
        if (wr_take) begin
          ctrl_d[CW_WE]                = 1'b1;
          ctrl_d[CW_ADDR_LSB +: 4]     = wr_addr;
          ctrl_d[CW_DATA_LSB +: 8]     = wr_data;
          wr_ready                     = 1'b1;
        end
      end else begin
        if (nxt_q <= 10'(CTRL_BITS)) begin
          cbit = ctrl_q[cidx];
        end
        if (pix_valid) begin
          pix_ready = 1'b1;
          w_d       = sym_width(1'b1, pix_sof, cbit);
          pix_d     = pix_data;
        end else begin
          w_d   = sym_width(1'b0, 1'b0, cbit);
          pix_d = '0;
        end
      end
    end
    clk_nib_d = clk_nibble(w_d, phase_d);
    sdi_nib_d = pix_d[{phase_d, 2'b00} +: 4];
  end

  // Sequencer and output-nibble registers; phase starts at 3 so the first
  // cycle after release decides symbol 0 (FRAME)
  always_ff @(posedge c or negedge reset_n) begin
    if (!reset_n) begin
      run_q   <= 1'b0;
      phase_q <= 2'd3;
      nxt_q   <= '0;
      w_q     <= W_IDLE0;
      pix_q   <= '0;
      ctrl_q  <= '0;
      clock_q <= '0;
      sdi_q   <= '0;
    end else begin
      run_q   <= 1'b1;
      phase_q <= phase_d;
      nxt_q   <= nxt_d;
      w_q     <= w_d;
      pix_q   <= pix_d;
      ctrl_q  <= ctrl_d;
      clock_q <= clk_nib_d;
      sdi_q   <= sdi_nib_d;
    end
  end

  display_host_rx u_rx (
    .c            (c),
    .reset_n      (reset_n),
    .sdo          (sdo),
    .sda_d        (sda_d),
    .scl_d        (scl_d),
    .fifostat     (fifostat),
    .status_valid (status_valid),
    .rdata        (rdata),
    .rdata_valid  (rdata_valid)
  );

endmodule

// File: tb/tb_display_host.sv
// Directed bench for display_host: tx symbol encoding, control word, write
// handshake, mid-symbol reset, and return-line status/readback deframing.
module tb_display_host;

  logic        c = 1'b0;
  logic        reset_n;
  logic [3:0]  clock_q, sdi_q;
  logic        sdo;
  logic        pix_valid, pix_sof;
  logic [15:0] pix_data;
  logic        pix_ready;
  logic        sda_t, scl_t;
  logic        wr_valid;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic        sda_d, scl_d, fifostat, status_valid;
  logic [15:0] rdata;
  logic        rdata_valid;

  int vec = 0;
  int bad = 0;
  int bsym = 0;

  display_host #(.CTRL_INTERVAL(64)) dut (
    .c(c), .reset_n(reset_n), .clock_q(clock_q), .sdi_q(sdi_q), .sdo(sdo),
    .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_data(pix_data),
    .pix_ready(pix_ready), .sda_t(sda_t), .scl_t(scl_t), .wr_valid(wr_valid),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready), .sda_d(sda_d),
    .scl_d(scl_d), .fifostat(fifostat), .status_valid(status_valid),
    .rdata(rdata), .rdata_valid(rdata_valid)
  );

  always #4 c = ~c;

  task automatic tick;
    @(posedge c);
    #1;
  endtask

  task automatic clear_inputs;
    pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
  endtask

  function automatic logic [15:0] mask(input int w);
    logic [31:0] m;
    m = (32'd1 << w) - 32'd1;
    return m[15:0];
  endfunction

  // From a boundary cycle: sample handshakes, then collect 4 nibbles.
  task automatic run_symbol(output logic [15:0] ck, output logic [15:0] sd,
                            output logic pr, output logic wrr, output int extra);
    #1;
    pr = pix_ready; wrr = wr_ready; extra = 0;
    for (int j = 0; j < 4; j++) begin
      tick();
      if (j == 0) clear_inputs();
      ck[4*j +: 4] = clock_q;
      sd[4*j +: 4] = sdi_q;
      if (j < 3) extra += int'(pix_ready) + int'(wr_ready);
    end
    bsym++;
  endtask

  task automatic skip_to(input int k);
    logic [15:0] ck, sd; logic pr, wrr; int ex;
    while (bsym < k) run_symbol(ck, sd, pr, wrr, ex);
  endtask

  task automatic do_reset;
    reset_n = 1'b0; clear_inputs(); sdo = 1'b0; sda_t = 1'b0; scl_t = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    bsym = 0;
  endtask

  task automatic send_pkt(input logic [5:0] b, output logic sv, output logic rv);
    sdo = 1'b1; tick();
    for (int i = 0; i < 6; i++) begin
      sdo = b[i]; tick();
    end
    sv = status_valid; rv = rdata_valid;
    sdo = 1'b0;
  endtask

  task automatic test_reset;
    logic [15:0] ck, sd; logic pr, wrr; int ex;
    reset_n = 1'b0; sdo = 1'b0; sda_t = 1'b1; scl_t = 1'b1;
    pix_valid = 1'b1; pix_sof = 1'b0; pix_data = 16'hFFFF;
    wr_valid = 1'b1; wr_addr = 4'hF; wr_data = 8'hFF;
    tick(); tick();
    vec++; if (clock_q !== 4'h0 || sdi_q !== 4'h0) begin bad++; $display("FAIL reset_lines clock_q=%h sdi_q=%h want 0 0", clock_q, sdi_q); end
    vec++; if (pix_ready !== 1'b0 || wr_ready !== 1'b0) begin bad++; $display("FAIL reset_ready pix_ready=%b wr_ready=%b want 0 0", pix_ready, wr_ready); end
    vec++; if ({sda_d, scl_d, fifostat, status_valid, rdata_valid} !== 5'b0 || rdata !== 16'h0) begin bad++; $display("FAIL reset_status got %b rdata=%h want 0", {sda_d, scl_d, fifostat, status_valid, rdata_valid}, rdata); end
    do_reset();
    run_symbol(ck, sd, pr, wrr, ex);
    vec++; if (ck !== 16'h0FFF || sd !== 16'h0) begin bad++; $display("FAIL first_frame clock=%h sdi=%h want 0fff 0000", ck, sd); end
    run_symbol(ck, sd, pr, wrr, ex);
    vec++; if (ck !== 16'h03FF || sd !== 16'h0) begin bad++; $display("FAIL first_idle clock=%h sdi=%h want 03ff 0000", ck, sd); end
  endtask

  task automatic test_pixel;
    logic [15:0] ck, sd; logic pr, wrr; int ex;
    skip_to(20);
    pix_valid = 1'b1; pix_sof = 1'b0; pix_data = 16'hA5C3;
    run_symbol(ck, sd, pr, wrr, ex);
    vec++; if (pr !== 1'b1 || ex !== 0) begin bad++; $display("FAIL pix_ready_pulse got %b extra=%0d want 1 0", pr, ex); end
    vec++; if (ck !== 16'h001F || sd !== 16'hA5C3) begin bad++; $display("FAIL pix_sym20 clock=%h sdi=%h want 001f a5c3", ck, sd); end
    pix_valid = 1'b1; pix_sof = 1'b1; pix_data = 16'h0F0F;
    run_symbol(ck, sd, pr, wrr, ex);
    vec++; if (ck !== 16'h003F || sd !== 16'h0F0F) begin bad++; $display("FAIL pix_sof clock=%h sdi=%h want 003f 0f0f", ck, sd); end
    wr_valid = 1'b1; wr_addr = 4'h1; wr_data = 8'h22;
    run_symbol(ck, sd, pr, wrr, ex);
    vec++; if (wrr !== 1'b0 || pr !== 1'b0 || ck !== 16'h03FF) begin bad++; $display("FAIL no_wr_midframe wr_ready=%b pix_ready=%b clock=%h want 0 0 03ff", wrr, pr, ck); end
  endtask

  task automatic test_write;
    logic [15:0] ck, sd; logic pr, wrr; int ex;
    logic [15:0] exp_w, got_w; logic cb, sof; int ew;
    exp_w = 16'h937E; got_w = '0;
    skip_to(64);
    sda_t = 1'b1; scl_t = 1'b0;
    wr_valid = 1'b1; wr_addr = 4'h3; wr_data = 8'h7E;
    pix_valid = 1'b1; pix_data = 16'hFFFF;
    run_symbol(ck, sd, pr, wrr, ex);
    sda_t = 1'b0;
    vec++; if (wrr !== 1'b1 || ex !== 0) begin bad++; $display("FAIL wr_ready_pulse got %b extra=%0d want 1 0", wrr, ex); end
    vec++; if (pr !== 1'b0 || ck !== 16'h0FFF || sd !== 16'h0) begin bad++; $display("FAIL frame_no_pix pix_ready=%b clock=%h sdi=%h want 0 0fff 0000", pr, ck, sd); end
    for (int k = 1; k <= 16; k++) begin
      sof = (k == 3);
      pix_valid = 1'b1; pix_sof = sof; pix_data = 16'h1000 + 16'(k);
      run_symbol(ck, sd, pr, wrr, ex);
      cb = exp_w[k-1];
      ew = cb ? (sof ? 9 : 8) : (sof ? 6 : 5);
      got_w[k-1] = ($countones(ck) == 8 || $countones(ck) == 9 || $countones(ck) == 7);
      vec++; if (ck !== mask(ew) || pr !== 1'b1 || sd !== 16'h1000 + 16'(k)) begin bad++; $display("FAIL cbit_sym%0d clock=%h pix_ready=%b sdi=%h want %h 1 %h", k, ck, pr, sd, mask(ew), 16'h1000 + 16'(k)); end
    end
    vec++; if (got_w !== 16'h937E) begin bad++; $display("FAIL ctrl_word got %h want 937e", got_w); end
    pix_valid = 1'b1; pix_data = 16'h0001;
    run_symbol(ck, sd, pr, wrr, ex);
    vec++; if (ck !== 16'h001F) begin bad++; $display("FAIL sym17_cbit0 clock=%h want 001f", ck); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    skip_to(5);
    pix_valid = 1'b1; pix_data = 16'h1234;
    tick(); clear_inputs(); tick();
    vec++; if (clock_q !== 4'h1 || sdi_q !== 4'h3) begin bad++; $display("FAIL pre_reset_nibble clock=%h sdi=%h want 1 3", clock_q, sdi_q); end
    reset_n = 1'b0; wr_valid = 1'b1; #1;
    vec++; if (clock_q !== 4'h0 || sdi_q !== 4'h0 || wr_ready !== 1'b0) begin bad++; $display("FAIL mid_reset clock=%h sdi=%h wr_ready=%b want 0 0 0", clock_q, sdi_q, wr_ready); end
    tick();
    clear_inputs(); reset_n = 1'b1; bsym = 0;
    begin
      logic [15:0] ck, sd; logic pr, wrr; int ex;
      run_symbol(ck, sd, pr, wrr, ex);
      vec++; if (ck !== 16'h0FFF || wrr !== 1'b0) begin bad++; $display("FAIL frame_after_reset clock=%h wr_ready=%b want 0fff 0", ck, wrr); end
    end
  endtask

  task automatic test_status;
    logic [8:0] stream; int pulses;
    stream = 9'b110101100;
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      if (status_valid === 1'b1) pulses++;
      sdo = stream[i]; tick();
    end
    vec++; if (status_valid !== 1'b1 || pulses !== 0) begin bad++; $display("FAIL status_pulse got %b early=%0d want 1 0", status_valid, pulses); end
    vec++; if ({scl_d, sda_d, fifostat} !== 3'b101) begin bad++; $display("FAIL status_fields scl/sda/fifo=%b want 101", {scl_d, sda_d, fifostat}); end
    sdo = 1'b0; tick();
    vec++; if (status_valid !== 1'b0 || rdata_valid !== 1'b0) begin bad++; $display("FAIL status_one_cycle sv=%b rv=%b want 0 0", status_valid, rdata_valid); end
  endtask

  task automatic send_word(input logic [15:0] word, input int nchunks,
                           output int svs, output int rvs, output logic last_rv);
    logic sv, rv; logic [5:0] b;
    svs = 0; rvs = 0; last_rv = 1'b0;
    for (int k = 0; k < nchunks; k++) begin
      b = {(k == 0), word[2*k+1], word[2*k], 1'b0, 1'b1, 1'b0};
      send_pkt(b, sv, rv);
      svs += int'(sv);
      rvs += int'(rv);
      last_rv = rv;
    end
  endtask

  task automatic test_rdata;
    int svs, rvs; logic lrv; logic sv, rv;
    send_word(16'h1234, 8, svs, rvs, lrv);
    vec++; if (svs !== 8 || rvs !== 1 || lrv !== 1'b1) begin bad++; $display("FAIL rdata_pulses status=%0d rdv=%0d last=%b want 8 1 1", svs, rvs, lrv); end
    vec++; if (rdata !== 16'h1234) begin bad++; $display("FAIL rdata_word got %h want 1234", rdata); end
    vec++; if ({scl_d, sda_d, fifostat} !== 3'b010) begin bad++; $display("FAIL pkt_fields scl/sda/fifo=%b want 010", {scl_d, sda_d, fifostat}); end
    tick();
    vec++; if (rdata_valid !== 1'b0) begin bad++; $display("FAIL rdata_one_cycle got %b want 0", rdata_valid); end
    send_word(16'h5555, 3, svs, rvs, lrv);
    send_word(16'hBEEF, 8, svs, rvs, lrv);
    vec++; if (rvs !== 1 || lrv !== 1'b1 || rdata !== 16'hBEEF) begin bad++; $display("FAIL restart rdv=%0d last=%b rdata=%h want 1 1 beef", rvs, lrv, rdata); end
    send_pkt(6'b011000, sv, rv);
    vec++; if (sv !== 1'b1 || rv !== 1'b0 || rdata !== 16'hBEEF) begin bad++; $display("FAIL orphan_chunk sv=%b rv=%b rdata=%h want 1 0 beef", sv, rv, rdata); end
  endtask

  initial begin
    clear_inputs(); sdo = 1'b0; sda_t = 1'b0; scl_t = 1'b0; reset_n = 1'b0;
    test_reset();
    test_pixel();
    test_write();
    test_reset_mid();
    test_status();
    test_rdata();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
